// File: rtl/ntt_pkg.sv
// Shared types for the NTT butterfly: tag width helper, butterfly mode, stage payload.
package ntt_pkg;

  function automatic int unsigned tag_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned BFLY_SIZE  = 20;
  localparam int unsigned BFLY_MOD   = 257;
  localparam int unsigned BFLY_DEPTH = 256;
  localparam int unsigned BFLY_TAGW  = tag_width(BFLY_DEPTH);

  typedef enum logic {
    BFLY_CT = 1'b0,
    BFLY_GS = 1'b1
  } bfly_mode_e;

  // a carries the wide product (or {w, d} for GS in S1); b carries the GS sum.
  typedef struct packed {
    bfly_mode_e                 mode;
    logic [BFLY_SIZE-1:0]       x;
    logic [2*BFLY_SIZE-1:0]     a;
    logic [BFLY_SIZE-1:0]       b;
    logic [BFLY_TAGW-1:0]       tag;
  } bfly_stage_t;

endpackage

// File: rtl/mod_reduce.sv
// Registered reduction of a 2*SIZE product modulo MOD, advancing with the pipeline.
module mod_reduce
  import ntt_pkg::*;
#(
  parameter int unsigned SIZE = BFLY_SIZE,
  parameter int unsigned MOD  = BFLY_MOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [2*SIZE-1:0] p_i,
  output logic [SIZE-1:0]   r_o
);

  localparam logic [2*SIZE-1:0] MOD_W = (2*SIZE)'(MOD);

  logic [SIZE-1:0] r_q, r_d;

  always_comb r_d = SIZE'(p_i % MOD_W);

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (en_i) r_q <= r_d;
  end

  assign r_o = r_q;

endmodule

// File: rtl/ntt_butterfly.sv
// 3-stage CT/GS modular butterfly with global-stall valid/ready flow control.
// Optional sticky operand range error enabled by NTT_BFLY_RANGE_CHECK_EN.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter  int unsigned SIZE  = BFLY_SIZE,
  parameter  int unsigned MOD   = BFLY_MOD,
  parameter  int unsigned DEPTH = BFLY_DEPTH,
  localparam int unsigned TAGW  = tag_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [SIZE-1:0] in_x,
  input  logic [SIZE-1:0] in_y,
  input  logic [SIZE-1:0] in_w,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_u,
  output logic [SIZE-1:0] out_v,
  output logic [TAGW-1:0] out_tag,
  output logic            err
);

  localparam logic [SIZE:0] MOD_X = (SIZE+1)'(MOD);

  logic        advance, accept;
  logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  bfly_stage_t s1_q, s1_d, s2_q, s2_d;
  bfly_mode_e  s3_mode_q, s3_mode_d;
  logic [SIZE-1:0] u_q, u_d, v_q, v_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [SIZE-1:0] ct_t, gs_v;
  logic [SIZE:0]   sum1, dif1, sum3, dif3;

  assign advance  = out_ready | ~s3_valid_q;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  always_comb begin
    sum1 = {1'b0, in_x} + {1'b0, in_y};
    if (sum1 >= MOD_X) sum1 = sum1 - MOD_X;
    if (in_x >= in_y) dif1 = {1'b0, in_x} - {1'b0, in_y};
    else              dif1 = {1'b0, in_x} + MOD_X - {1'b0, in_y};
    s1_d      = '0;
    s1_d.mode = bfly_mode_e'(in_mode);
    s1_d.x    = in_x;
    s1_d.tag  = in_tag;
    if (s1_d.mode == BFLY_GS) begin
      // twiddle rides in the upper half of a until the S2 multiply
      s1_d.a = {in_w, SIZE'(dif1)};
      s1_d.b = SIZE'(sum1);
    end else begin
      s1_d.a = {{SIZE{1'b0}}, in_w} * {{SIZE{1'b0}}, in_y};
    end
    s1_valid_d = accept;
  end

  always_comb begin
    s2_d = s1_q;
    if (s1_q.mode == BFLY_GS)
      s2_d.a = {{SIZE{1'b0}}, s1_q.a[SIZE-1:0]} * {{SIZE{1'b0}}, s1_q.a[2*SIZE-1:SIZE]};
    s2_valid_d = s1_valid_q;
  end

  always_comb begin
    sum3 = {1'b0, s2_q.x} + {1'b0, ct_t};
    if (sum3 >= MOD_X) sum3 = sum3 - MOD_X;
    if (s2_q.x >= ct_t) dif3 = {1'b0, s2_q.x} - {1'b0, ct_t};
    else                dif3 = {1'b0, s2_q.x} + MOD_X - {1'b0, ct_t};
    if (s2_q.mode == BFLY_GS) begin
      u_d = s2_q.b;
      v_d = '0;
    end else begin
      u_d = SIZE'(sum3);
      v_d = SIZE'(dif3);
    end
    s3_mode_d  = s2_q.mode;
    tag_d      = s2_q.tag;
    s3_valid_d = s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_mode_q  <= BFLY_CT;
      u_q        <= '0;
      v_q        <= '0;
      tag_q      <= '0;
    end else if (advance) begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_mode_q  <= s3_mode_d;
      u_q        <= u_d;
      v_q        <= v_d;
      tag_q      <= tag_d;
    end
  end

  mod_reduce #(.SIZE(SIZE), .MOD(MOD)) u_ct_red (
    .clk  (clk),
    .rst  (rst),
    .en_i (advance),
    .p_i  (s1_q.a),
    .r_o  (ct_t)
  );

  mod_reduce #(.SIZE(SIZE), .MOD(MOD)) u_gs_red (
    .clk  (clk),
    .rst  (rst),
    .en_i (advance),
    .p_i  (s2_q.a),
    .r_o  (gs_v)
  );

  assign out_valid = s3_valid_q;
  assign out_u     = u_q;
  assign out_v     = (s3_mode_q == BFLY_GS) ? gs_v : v_q;
  assign out_tag   = tag_q;

`ifdef NTT_BFLY_RANGE_CHECK_EN
  localparam logic [SIZE-1:0] MOD_S = SIZE'(MOD);

  logic err_q, err_d;

  always_comb err_d = err_q | (accept & ((in_x >= MOD_S) | (in_y >= MOD_S) | (in_w >= MOD_S)));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed vectors, throughput, stall, reset, random traffic.
module tb_ntt_butterfly;

  localparam int unsigned SIZE = 20;
  localparam int unsigned MOD  = 257;
  localparam int unsigned TAGW = 8;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_mode, out_valid, out_ready, err;
  logic [SIZE-1:0] in_x, in_y, in_w, out_u, out_v;
  logic [TAGW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  ntt_butterfly #(.SIZE(SIZE), .MOD(MOD), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_w      (in_w),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_u     (out_u),
    .out_v     (out_v),
    .out_tag   (out_tag),
    .err       (err)
  );

  typedef struct {
    logic [SIZE-1:0] u;
    logic [SIZE-1:0] v;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic exp_t model(input bit mode, input longint x, input longint y,
                                 input longint w, input logic [TAGW-1:0] tag);
    exp_t   e;
    longint m, t, d;
    m = MOD;
    if (!mode) begin
      t   = (w * y) % m;
      e.u = SIZE'((x + t) % m);
      e.v = SIZE'((x - t + m) % m);
    end else begin
      d   = (x - y + m) % m;
      e.u = SIZE'((x + y) % m);
      e.v = SIZE'((d * w) % m);
    end
    e.tag = tag;
    return e;
  endfunction

  task automatic drive(input bit v, input bit mode, input int unsigned x, input int unsigned y,
                       input int unsigned w, input int unsigned tag);
    in_valid = v;
    in_mode  = mode;
    in_x     = SIZE'(x);
    in_y     = SIZE'(y);
    in_w     = SIZE'(w);
    in_tag   = TAGW'(tag);
  endtask

  task automatic drive_rand(input bit v, input bit mode);
    drive(v, mode, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1),
          $urandom_range(0, MOD-1), $urandom_range(0, 255));
  endtask

  // Record handshakes due at the coming edge, score any output transfer, then advance.
  task automatic step();
    exp_t e;
    #1;
    if (in_valid === 1'b1 && in_ready === 1'b1)
      sb.push_back(model(in_mode, in_x, in_y, in_w, in_tag));
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL result: unexpected output u=%0d v=%0d tag=%0d, none outstanding",
                 out_u, out_v, out_tag);
      end else begin
        e = sb.pop_front();
        if ({out_u, out_v, out_tag} !== {e.u, e.v, e.tag}) begin
          bad++;
          $display("FAIL result: got u=%0d v=%0d tag=%0d want u=%0d v=%0d tag=%0d",
                   out_u, out_v, out_tag, e.u, e.v, e.tag);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++;
    if ({out_u, out_v, out_tag} !== '0) begin
      bad++;
      $display("FAIL reset_data: got u=%0d v=%0d tag=%0d want 0", out_u, out_v, out_tag);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int unsigned dm [4] = '{0, 1, 0, 1};
    int unsigned dx [4] = '{5, 5, 256, 0};
    int unsigned dy [4] = '{7, 7, 256, 256};
    int unsigned dw [4] = '{3, 3, 256, 1};
    int unsigned dt [4] = '{9, 17, 33, 200};
    int unsigned du [4] = '{26, 12, 0, 256};
    int unsigned dv [4] = '{241, 251, 255, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, dm[i][0], dx[i], dy[i], dw[i], dt[i]);
      step();
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
        total++;
        if (out_valid !== 1'(k == 3)) begin
          bad++;
          $display("FAIL latency[%0d] cycle %0d: got out_valid=%b want %b", i, k, out_valid, k == 3);
        end
        if (k == 3) begin
          total++;
          if (out_u !== SIZE'(du[i]) || out_v !== SIZE'(dv[i]) || out_tag !== TAGW'(dt[i])) begin
            bad++;
            $display("FAIL directed[%0d]: got u=%0d v=%0d tag=%0d want u=%0d v=%0d tag=%0d",
                     i, out_u, out_v, out_tag, du[i], dv[i], dt[i]);
          end
        end
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive_rand(1, c[0]);
      else       drive(0, 0, 0, 0, 0, 0);
      total++;
      if (out_valid !== 1'(c >= 3 && c <= 10)) begin
        bad++;
        $display("FAIL b2b_valid cycle %0d: got %b want %b", c, out_valid, c >= 3 && c <= 10);
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cycle %0d: got %b want 1", c, in_ready); end
      step();
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_rand(1, 1'($urandom_range(0, 1)));
      step();
    end
    out_ready = 1'b0;
    for (int c = 3; c < 7; c++) begin
      drive_rand(1, 1'($urandom_range(0, 1)));
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cycle %0d: got %b want 0", c, in_ready); end
      total++;
      if (out_valid !== 1'b1 || out_u !== sb[0].u || out_v !== sb[0].v || out_tag !== sb[0].tag) begin
        bad++;
        $display("FAIL stall_hold cycle %0d: got valid=%b u=%0d v=%0d tag=%0d want valid=1 u=%0d v=%0d tag=%0d",
                 c, out_valid, out_u, out_v, out_tag, sb[0].u, sb[0].v, sb[0].tag);
      end
      step();
    end
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 7; c < 11; c++) begin
      total++;
      if (out_valid !== 1'(c <= 9)) begin
        bad++;
        $display("FAIL stall_release cycle %0d: got %b want %b", c, out_valid, c <= 9);
      end
      step();
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL stall_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    drive_rand(1, 0);
    step();
    drive_rand(1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 6; c++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush cycle %0d: got out_valid=%b want 0", c, out_valid); end
      step();
    end
  endtask

  task automatic test_random();
    int n;
    for (int c = 0; c < 400; c++) begin
      drive_rand($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL random_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_err();
    bit exp_err;
`ifdef NTT_BFLY_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    out_ready = 1'b0;
    drive(1, 0, 300, 7, 3, 1);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", err); end
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (err !== exp_err) begin bad++; $display("FAIL err_hold cycle %0d: got %b want %b", c, err, exp_err); end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
